pingpong_vec_buffer: RTL

- Double-banked (ping-pong) vector buffer for the softmax datapath.
- The producer streams a vector into one bank while the consumer drains the other bank. Both sides use a valid/ready handshake.
- Each bank holds one vector of up to 2^ADDR_WIDTH elements. Its length is recorded at commit so the normalizer knows the vector size.
- Successor to the single-port sync buffer: it adds banking, handshakes, per-bank length tracking and zero-bubble streaming reads.

---
 rtl/pingpong_vec_buffer_if.sv | 33 +++
 rtl/pingpong_vec_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pingpong_vec_buffer_if.sv
// Producer/consumer port bundle of the ping-pong vector buffer.
// The master side is the softmax datapath, the slave side is the buffer.
interface pingpong_vec_buffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   // Producer channel
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_last;
   logic                  wr_trunc;

   // Consumer channel
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;
   logic [ADDR_WIDTH:0]   rd_len;

   // Occupancy
   logic [1:0]            full_cnt;

   modport master (
      output wr_valid, wr_data, wr_last, rd_ready,
      input  wr_ready, wr_trunc, rd_valid, rd_data, rd_last, rd_len, full_cnt
   );

   modport slave (
      input  wr_valid, wr_data, wr_last, rd_ready,
      output wr_ready, wr_trunc, rd_valid, rd_data, rd_last, rd_len, full_cnt
   );
endinterface

// File: rtl/pingpong_vec_buffer.sv
// Two-bank vector buffer: the producer fills one bank while the consumer
// streams the other out with registered, zero-bubble reads.
module pingpong_vec_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pingpong_vec_buffer_if.slave   bus_if
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] B_FREE    = 2'd0;
   localparam logic [1:0] B_FILLING = 2'd1;
   localparam logic [1:0] B_FULL    = 2'd2;

   localparam logic [0:0] R_IDLE   = 1'b0;
   localparam logic [0:0] R_STREAM = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);

   // NOTE: bank storage has no reset; only the control state that says which
   // bank holds valid data is cleared, so stale contents are never observed.
   logic [DATA_WIDTH-1:0] mem_q [2*DEPTH];

   logic [1:0][1:0]        bank_state_q, bank_state_d;
   logic [1:0][ADDR_WIDTH:0] len_q, len_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
   logic [0:0]             rd_state_q, rd_state_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   rd_last_q, rd_last_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [ADDR_WIDTH:0]    rd_len_q, rd_len_d;
   logic                   wr_trunc_q, wr_trunc_d;
   logic [1:0]             full_cnt_q, full_cnt_d;

   logic wr_ready;
   logic wr_fire;
   logic wr_at_end;
   logic wr_commit;
   logic rd_adv;
   logic rd_release;

   always_comb begin
      wr_ready   = (bank_state_q[wr_bank_q] != B_FULL);
      wr_fire    = bus_if.wr_valid && wr_ready;
      wr_at_end  = (wr_ptr_q == PTR_LAST);
      wr_commit  = wr_fire && (bus_if.wr_last || wr_at_end);
      rd_adv     = !rd_valid_q || bus_if.rd_ready;
      rd_release = rd_valid_q && bus_if.rd_ready && rd_last_q;
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a variable
      // unassigned, which would otherwise infer a latch.
      bank_state_d = bank_state_q;
      len_d        = len_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rd_state_d   = rd_state_q;
      rd_valid_d   = rd_valid_q;
      rd_last_d    = rd_last_q;
      rd_data_d    = rd_data_q;
      rd_len_d     = rd_len_q;
      wr_trunc_d   = wr_fire && wr_at_end && !bus_if.wr_last;
      full_cnt_d   = full_cnt_q + 2'(wr_commit) - 2'(rd_release);

      // Write side never touches the read bank: it is FULL, the write bank is not.
      if (wr_fire) begin
         bank_state_d[wr_bank_q] = B_FILLING;
         wr_ptr_d                = wr_ptr_q + ADDR_WIDTH'(1);
         if (wr_commit) begin
            bank_state_d[wr_bank_q] = B_FULL;
            len_d[wr_bank_q]        = {1'b0, wr_ptr_q} + LEN_ONE;
            wr_bank_d               = ~wr_bank_q;
            wr_ptr_d                = '0;
         end
      end

      case (rd_state_q)
         R_IDLE: begin
            if (bank_state_q[rd_bank_q] == B_FULL && rd_adv) begin
               rd_data_d  = mem_q[{rd_bank_q, {ADDR_WIDTH{1'b0}}}];
               rd_valid_d = 1'b1;
               rd_len_d   = len_q[rd_bank_q];
               rd_last_d  = (len_q[rd_bank_q] == LEN_ONE);
               rd_ptr_d   = LEN_ONE;
               rd_state_d = R_STREAM;
            end
         end
         R_STREAM: begin
            if (rd_release) begin
               bank_state_d[rd_bank_q] = B_FREE;
               rd_bank_d  = ~rd_bank_q;
               rd_ptr_d   = '0;
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
               rd_state_d = R_IDLE;
            end else if (rd_adv && rd_ptr_q < rd_len_q) begin
               rd_data_d  = mem_q[{rd_bank_q, rd_ptr_q[ADDR_WIDTH-1:0]}];
               rd_valid_d = 1'b1;
               rd_last_d  = (rd_ptr_q == rd_len_q - LEN_ONE);
               rd_ptr_d   = rd_ptr_q + LEN_ONE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[{wr_bank_q, wr_ptr_q}] <= bus_if.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_state_q <= {B_FREE, B_FREE};
         len_q        <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_state_q   <= R_IDLE;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_data_q    <= '0;
         rd_len_q     <= '0;
         wr_trunc_q   <= 1'b0;
         full_cnt_q   <= '0;
      end else begin
         bank_state_q <= bank_state_d;
         len_q        <= len_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_state_q   <= rd_state_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
         rd_data_q    <= rd_data_d;
         rd_len_q     <= rd_len_d;
         wr_trunc_q   <= wr_trunc_d;
         full_cnt_q   <= full_cnt_d;
      end
   end

   assign bus_if.wr_ready = wr_ready;
   assign bus_if.wr_trunc = wr_trunc_q;
   assign bus_if.rd_valid = rd_valid_q;
   assign bus_if.rd_data  = rd_data_q;
   assign bus_if.rd_last  = rd_last_q;
   assign bus_if.rd_len   = rd_len_q;
   assign bus_if.full_cnt = full_cnt_q;

endmodule
